// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN stack controller: opcodes, FSM encoding, ALU.
package rpn_pkg;

  localparam logic [7:0] OP_ADD  = 8'h00;
  localparam logic [7:0] OP_SUB  = 8'h01;
  localparam logic [7:0] OP_AND  = 8'h02;
  localparam logic [7:0] OP_OR   = 8'h03;
  localparam logic [7:0] OP_XOR  = 8'h04;
  localparam logic [7:0] OP_EMIT = 8'h05;
  localparam logic [7:0] OP_CLR  = 8'h06;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PUSH_OPD,
    ST_POP_B,
    ST_CAP_B,
    ST_POP_A,
    ST_CAP_A,
    ST_PUSH_R,
    ST_POP_E,
    ST_CAP_E,
    ST_CLR_R,
    ST_ERR
  } state_t;

  // 8-bit wrap-around arithmetic/logic; a is the deeper entry, b the top.
  function automatic logic [7:0] alu8(input logic [7:0] op,
                                      input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] y;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      default: y = 8'h00;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/lifo_stack.sv
// Simple synchronous LIFO: registered dout valid the cycle after pop.
module lifo_stack #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     sp_q;
  logic [PW-1:0]     top_idx;
  logic              do_push;
  logic              do_pop;

  assign full    = (sp_q == PW'(DEPTH));
  assign empty   = (sp_q == '0);
  assign top_idx = sp_q - PW'(1);
  assign do_push = push && !full;
  assign do_pop  = pop && !push && !empty;

  // Stack pointer and registered read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q <= '0;
      dout <= '0;
    end else if (do_push) begin
      sp_q <= sp_q + PW'(1);
    end else if (do_pop) begin
      sp_q <= top_idx;
      dout <= mem[top_idx[AW-1:0]];
    end
  end

  // Storage array write.
  always_ff @(posedge clk) begin
    if (do_push) mem[sp_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/rpn_alu8.sv
// Combinational 8-bit ALU wrapper around the shared alu8 function.
module rpn_alu8
  import rpn_pkg::*;
(
  input  logic [7:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y
);

  assign y = alu8(op, a, b);

endmodule

// File: rtl/rpn_stack_ctrl.sv
// Token-driven RPN evaluator steering an external lifo_stack.
module rpn_stack_ctrl
  import rpn_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tok_valid,
  output logic       tok_ready,
  input  logic       tok_is_op,
  input  logic [7:0] tok_data,
  input  logic       err_clr,
  output logic       res_valid,
  output logic [7:0] res_data,
  output logic       err,
  output logic       stk_push,
  output logic       stk_pop,
  output logic [7:0] stk_din,
  input  logic [7:0] stk_dout,
  input  logic       stk_full,
  input  logic       stk_empty
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [7:0]    a_q, b_q, op_q, din_q, res_q;
  logic [7:0]    alu_y;
  logic          accept;

  assign tok_ready = (state_q == ST_IDLE) && !rst;
  assign accept    = tok_valid && tok_ready;

  rpn_alu8 u_alu (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .y  (alu_y)
  );

  // Next-state decode and per-state stack/result outputs.
  always_comb begin
    state_d   = state_q;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    stk_din   = 8'h00;
    res_valid = 1'b0;
    res_data  = 8'h00;
    err       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!tok_is_op) begin
            state_d = (cnt_q == FULL_CNT || stk_full) ? ST_ERR : ST_PUSH_OPD;
          end else begin
            case (tok_data)
              OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:
                state_d = (cnt_q < CW'(2)) ? ST_ERR : ST_POP_B;
              OP_EMIT: state_d = (cnt_q == '0) ? ST_ERR : ST_POP_E;
              OP_CLR:  state_d = ST_CLR_R;
              default: state_d = ST_ERR;
            endcase
          end
        end
      end
      ST_PUSH_OPD: state_d = ST_IDLE;
      ST_POP_B:    state_d = ST_CAP_B;
      ST_CAP_B:    state_d = ST_POP_A;
      ST_POP_A:    state_d = ST_CAP_A;
      ST_CAP_A:    state_d = ST_PUSH_R;
      ST_PUSH_R:   state_d = ST_IDLE;
      ST_POP_E:    state_d = ST_CAP_E;
      ST_CAP_E:    state_d = ST_IDLE;
      ST_CLR_R:    state_d = ST_IDLE;
      ST_ERR:      if (err_clr) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase

    // Outputs are forced quiet while reset is asserted so an aborted
    // sequence cannot leak a push/pop into the reset cycle.
    if (!rst) begin
      res_data = res_q;
      case (state_q)
        ST_PUSH_OPD: begin
          stk_push = 1'b1;
          stk_din  = din_q;
        end
        ST_POP_B, ST_POP_A, ST_POP_E: stk_pop = 1'b1;
        ST_PUSH_R: begin
          stk_push = 1'b1;
          stk_din  = alu_y;
        end
        ST_CAP_E: begin
          res_valid = 1'b1;
          res_data  = stk_dout;
        end
        ST_CLR_R: begin
          res_valid = 1'b1;
          res_data  = 8'(cnt_q);
        end
        ST_ERR:  err = 1'b1;
        default: ;
      endcase
    end
  end

  // State register and occupancy count; count tracks net stack changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_PUSH_OPD:        cnt_q <= cnt_q + CW'(1);
        ST_PUSH_R, ST_CAP_E: cnt_q <= cnt_q - CW'(1);
        default: ;
      endcase
    end
  end

  // Operand, opcode and result capture registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= 8'h00;
      b_q   <= 8'h00;
      op_q  <= 8'h00;
      din_q <= 8'h00;
      res_q <= 8'h00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q <= tok_data;
            if (!tok_is_op) din_q <= tok_data;
          end
        end
        ST_CAP_B: b_q   <= stk_dout;
        ST_CAP_A: a_q   <= stk_dout;
        ST_CAP_E: res_q <= stk_dout;
        ST_CLR_R: res_q <= 8'(cnt_q);
        default: ;
      endcase
    end
  end

  // Between tokens the local count and the stack's empty flag must agree.
  always @(posedge clk) begin
    if (!rst && state_q == ST_IDLE) assert (stk_empty == (cnt_q == '0));
  end

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Bench pairing rpn_stack_ctrl with a 4-deep lifo_stack.
module tb_rpn_stack_ctrl;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic       clk = 1'b0;
  logic       rst, tok_valid, tok_is_op, err_clr;
  logic [7:0] tok_data;
  logic       tok_ready, res_valid, err, stk_push, stk_pop, stk_full, stk_empty;
  logic [7:0] res_data, stk_din, stk_dout;

  always #5 clk = ~clk;

  rpn_stack_ctrl #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .tok_valid (tok_valid),
    .tok_ready (tok_ready),
    .tok_is_op (tok_is_op),
    .tok_data  (tok_data),
    .err_clr   (err_clr),
    .res_valid (res_valid),
    .res_data  (res_data),
    .err       (err),
    .stk_push  (stk_push),
    .stk_pop   (stk_pop),
    .stk_din   (stk_din),
    .stk_dout  (stk_dout),
    .stk_full  (stk_full),
    .stk_empty (stk_empty)
  );

  lifo_stack #(.DEPTH(DEPTH), .DATA_W(8)) u_stk (
    .clk   (clk),
    .rst   (rst),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (stk_din),
    .dout  (stk_dout),
    .full  (stk_full),
    .empty (stk_empty)
  );

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Observations of the most recent token, indexed by cycle offset from accept.
  logic [7:0] push_mask, pop_mask, last_res;
  int         res_cnt, ready_at;
  logic       err_seen;

  task automatic issue(input logic is_op, input logic [7:0] d);
    int n;
    n = 0;
    push_mask = 8'h00; pop_mask = 8'h00; last_res = 8'h00;
    res_cnt = 0; ready_at = 0; err_seen = 1'b0;
    @(negedge clk);
    while (!tok_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!tok_ready) begin
      check("ready_wait", 32'(tok_ready), 32'd1);
    end else begin
      tok_valid = 1'b1; tok_is_op = is_op; tok_data = d;
      @(posedge clk);
      #1;
      tok_valid = 1'b0; tok_is_op = 1'b0; tok_data = 8'h00;
      for (int k = 1; k <= 7; k++) begin
        @(negedge clk);
        if (stk_push)  push_mask[k] = 1'b1;
        if (stk_pop)   pop_mask[k]  = 1'b1;
        if (res_valid) begin
          res_cnt++;
          last_res = res_data;
        end
        if (err) begin
          err_seen = 1'b1;
          break;
        end
        if (tok_ready) begin
          ready_at = k;
          break;
        end
      end
    end
  endtask

  task automatic pulse_err_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    @(negedge clk);
    check("errclr_ready", 32'(tok_ready), 32'd1);
    check("errclr_err", 32'(err), 32'd0);
  endtask

  typedef struct {
    logic       is_op;
    logic [7:0] data;
    logic [7:0] push_m;
    logic [7:0] pop_m;
    int         rdy;
    int         res_n;
    logic [7:0] res;
  } vec_t;

  function automatic vec_t v_opd(input logic [7:0] d);
    vec_t v;
    v = '{1'b0, d, 8'b0000_0010, 8'h00, 2, 0, 8'h00};
    return v;
  endfunction

  function automatic vec_t v_bin(input logic [7:0] op);
    vec_t v;
    v = '{1'b1, op, 8'b0010_0000, 8'b0000_1010, 6, 0, 8'h00};
    return v;
  endfunction

  function automatic vec_t v_emit(input logic [7:0] r);
    vec_t v;
    v = '{1'b1, 8'h05, 8'h00, 8'b0000_0010, 3, 1, r};
    return v;
  endfunction

  function automatic vec_t v_clr(input logic [7:0] r);
    vec_t v;
    v = '{1'b1, 8'h06, 8'h00, 8'h00, 2, 1, r};
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int held_push;
    rst = 1'b1; tok_valid = 1'b0; tok_is_op = 1'b0; tok_data = 8'h00; err_clr = 1'b0;

    tbl.push_back(v_opd(8'h03)); tbl.push_back(v_opd(8'h05));
    tbl.push_back(v_bin(8'h00)); tbl.push_back(v_emit(8'h08));
    tbl.push_back(v_opd(8'h0A)); tbl.push_back(v_opd(8'h03));
    tbl.push_back(v_bin(8'h01)); tbl.push_back(v_emit(8'h07));
    tbl.push_back(v_opd(8'hFF)); tbl.push_back(v_opd(8'h02));
    tbl.push_back(v_bin(8'h00)); tbl.push_back(v_emit(8'h01));
    tbl.push_back(v_opd(8'hF0)); tbl.push_back(v_opd(8'h3C));
    tbl.push_back(v_bin(8'h04)); tbl.push_back(v_emit(8'hCC));
    tbl.push_back(v_opd(8'hC3)); tbl.push_back(v_opd(8'h5A));
    tbl.push_back(v_bin(8'h02)); tbl.push_back(v_emit(8'h42));
    tbl.push_back(v_opd(8'hC0)); tbl.push_back(v_opd(8'h0C));
    tbl.push_back(v_bin(8'h03)); tbl.push_back(v_emit(8'hCC));
    tbl.push_back(v_opd(8'h10)); tbl.push_back(v_opd(8'h20));
    tbl.push_back(v_clr(8'h02));
    tbl.push_back(v_bin(8'h01)); tbl.push_back(v_emit(8'hF0));

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(tok_ready), 32'd0);
    check("rst_push", 32'(stk_push), 32'd0);
    check("rst_pop", 32'(stk_pop), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(tok_ready), 32'd1);
    check("idle_err", 32'(err), 32'd0);
    check("idle_res_valid", 32'(res_valid), 32'd0);
    check("idle_res_data", 32'(res_data), 32'd0);
    check("idle_din", 32'(stk_din), 32'd0);
    check("idle_empty", 32'(stk_empty), 32'd1);

    // Directed token table: arithmetic, wrap, and cycle offsets
    for (int i = 0; i < tbl.size(); i++) begin
      issue(tbl[i].is_op, tbl[i].data);
      check($sformatf("v%0d_push_mask", i), 32'(push_mask), 32'(tbl[i].push_m));
      check($sformatf("v%0d_pop_mask", i), 32'(pop_mask), 32'(tbl[i].pop_m));
      check($sformatf("v%0d_ready_at", i), 32'(ready_at), 32'(tbl[i].rdy));
      check($sformatf("v%0d_err", i), 32'(err_seen), 32'd0);
      check($sformatf("v%0d_res_cnt", i), 32'(res_cnt), 32'(tbl[i].res_n));
      if (tbl[i].res_n != 0)
        check($sformatf("v%0d_res", i), 32'(last_res), 32'(tbl[i].res));
    end
    check("tbl_end_empty", 32'(stk_empty), 32'd1);
    check("tbl_end_err", 32'(err), 32'd0);

    // Underflow on a fresh stack
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    issue(1'b1, 8'h00);
    check("uf_err", 32'(err_seen), 32'd1);
    check("uf_pop", 32'(pop_mask), 32'd0);
    check("uf_push", 32'(push_mask), 32'd0);
    @(negedge clk);
    check("uf_ready", 32'(tok_ready), 32'd0);
    check("uf_err_sticky", 32'(err), 32'd1);
    // A token held during ERR must be ignored
    held_push = 0;
    tok_valid = 1'b1; tok_is_op = 1'b0; tok_data = 8'h77;
    repeat (3) begin
      @(negedge clk);
      if (stk_push) held_push++;
    end
    tok_valid = 1'b0; tok_data = 8'h00;
    check("err_hold_push", 32'(held_push), 32'd0);
    check("err_hold_err", 32'(err), 32'd1);
    pulse_err_clr();

    // Illegal opcode
    issue(1'b1, 8'h07);
    check("illegal_err", 32'(err_seen), 32'd1);
    pulse_err_clr();

    // Overflow with a 4-deep stack
    issue(1'b0, 8'h11); check("fill1_push", 32'(push_mask), 32'h02);
    issue(1'b0, 8'h22); check("fill2_push", 32'(push_mask), 32'h02);
    issue(1'b0, 8'h33); check("fill3_push", 32'(push_mask), 32'h02);
    issue(1'b0, 8'h44); check("fill4_push", 32'(push_mask), 32'h02);
    check("fill_full", 32'(stk_full), 32'd1);
    issue(1'b0, 8'h55);
    check("ovf_err", 32'(err_seen), 32'd1);
    check("ovf_push", 32'(push_mask), 32'd0);
    check("ovf_full", 32'(stk_full), 32'd1);
    pulse_err_clr();
    issue(1'b1, 8'h05);
    check("ovf_emit_cnt", 32'(res_cnt), 32'd1);
    check("ovf_emit_res", 32'(last_res), 32'h44);

    // Reset during CAP_B of an ADD (stack holds 0x11,0x22,0x33)
    @(negedge clk);
    tok_valid = 1'b1; tok_is_op = 1'b1; tok_data = 8'h00;
    @(posedge clk);
    #1;
    tok_valid = 1'b0; tok_is_op = 1'b0;
    @(negedge clk);
    check("abort_popb_pop", 32'(stk_pop), 32'd1);
    check("abort_res_held", 32'(res_data), 32'h44);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("abort_ready", 32'(tok_ready), 32'd0);
    check("abort_push", 32'(stk_push), 32'd0);
    check("abort_pop", 32'(stk_pop), 32'd0);
    check("abort_res_valid", 32'(res_valid), 32'd0);
    check("abort_res_data", 32'(res_data), 32'd0);
    check("abort_err", 32'(err), 32'd0);
    check("abort_din", 32'(stk_din), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(tok_ready), 32'd1);
    check("post_rst_push", 32'(stk_push), 32'd0);
    check("post_rst_empty", 32'(stk_empty), 32'd1);
    issue(1'b1, 8'h05);
    check("post_rst_emit_err", 32'(err_seen), 32'd1);
    check("post_rst_emit_pop", 32'(pop_mask), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
